// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 requester.
//
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns one response per command. A wait counter aborts a transfer when
// the slave holds PREADY low for TIMEOUT ACCESS cycles.
//
// Ports:
//   PCLK, PRESET             clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    response payload
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA            APB requester outputs (all registered)
//   PREADY/PSLVERR/PRDATA    APB completer inputs
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// S_ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// S_RESP   | rsp_valid high, response held until rsp_ready

module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t                 state_q,       state_d;
  logic                   cmd_ready_q,   cmd_ready_d;
  logic                   psel_q,        psel_d;
  logic                   penable_q,     penable_d;
  logic                   pwrite_q,      pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_q,       paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_q,      pwdata_d;
  logic                   rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q,   rsp_rdata_d;
  logic                   rsp_err_q,     rsp_err_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]       cnt_q,         cnt_d;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = 1'b0;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready_q is low for the first cycle after reset, so the
        // handshake uses the registered value the requester actually sees.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          cnt_d       = '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        // PREADY wins over the timeout on the last allowed cycle.
        if (PREADY) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master.
//
// The driver issues commands and pushes the expected response (from a
// transaction-level memory model) into a queue; a slave model answers on
// the APB bus with per-transfer wait/error settings; a monitor pops and
// compares whenever a response handshake happens.

module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: rsp_ready high, 1: random, 2: held low

  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wt;
    logic          err;
    int            hs;
  } bus_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            lat;
    int            hs;
  } exp_t;

  bus_t          bus_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] mmem [256];
  logic [DW-1:0] smem [256];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave: answers on the bus and checks protocol every cycle.
  initial begin
    bus_t cur;
    int   acc;
    bit   have;
    bit   prev_psel;
    acc = 0; have = 0; prev_psel = 0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = $urandom;
      if (PSEL === 1'b1 && PENABLE === 1'b0) begin
        chk("setup_after_idle", prev_psel, 0);
        chk("setup_expected", bus_q.size() > 0, 1);
        if (bus_q.size() > 0) begin
          cur  = bus_q.pop_front();
          have = 1;
          acc  = 0;
          chk("setup_cycle", cyc, cur.hs + 1);
        end
      end
      if (PSEL === 1'b1 && have) begin
        chk("paddr", PADDR, cur.addr);
        chk("pwrite", PWRITE, cur.wr);
        chk("pwdata", PWDATA, cur.wr ? cur.wdata : '0);
      end
      if (PENABLE === 1'b1) chk("penable_needs_psel", PSEL, 1);
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        chk("access_after_setup", prev_psel, 1);
        if (have && acc == cur.wt) begin
          PREADY  = 1'b1;
          PSLVERR = cur.err;
          if (!cur.wr) PRDATA = smem[cur.addr];
          else if (!cur.err) smem[cur.addr] = cur.wdata;
        end
        acc++;
        chk("access_len_bound", acc <= TO, 1);
      end
      if (PSEL === 1'b1) begin
        chk("busy_cmd_ready_low", cmd_ready, 0);
        chk("busy_rsp_valid_low", rsp_valid, 0);
      end
      prev_psel = (PSEL === 1'b1);
    end
  end

  // Monitor: drives rsp_ready, pops the scoreboard on each response handshake.
  initial begin
    exp_t          e;
    bit            prev_stall, prev_valid;
    logic [DW-1:0] h_rdata;
    logic          h_err, h_tmo;
    int            rsp_start;
    prev_stall = 0; prev_valid = 0; rsp_start = 0;
    h_rdata = '0; h_err = 0; h_tmo = 0;
    rsp_ready = 1'b1;
    forever begin
      @(negedge PCLK);
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
      if (prev_stall) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_rdata", rsp_rdata, h_rdata);
        chk("hold_err", rsp_err, h_err);
        chk("hold_timeout", rsp_timeout, h_tmo);
      end
      if (rsp_valid === 1'b1 && !prev_valid) rsp_start = cyc;
      if (rsp_valid === 1'b1 && rsp_ready) begin
        chk("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_timeout", rsp_timeout, e.tmo);
          chk("rsp_latency", rsp_start - e.hs, e.lat);
        end
      end
      prev_stall = (rsp_valid === 1'b1) && !rsp_ready;
      prev_valid = (rsp_valid === 1'b1);
      h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout;
    end
  end

  // Call at a negedge. Returns at the negedge after the handshake.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int wt, input logic er, output int hs);
    bus_t b;
    exp_t e;
    int   n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    chk("cmd_accept_bound", n < 200, 1);
    hs = cyc;
    b.wr = wr; b.addr = a; b.wdata = d; b.wt = wt; b.err = er; b.hs = hs;
    bus_q.push_back(b);
    e.hs = hs;
    if (wt >= TO) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.lat = 3 + TO - 1;
    end else begin
      e.rdata = wr ? '0 : mmem[a];
      e.err   = er;
      e.tmo   = 1'b0;
      e.lat   = 3 + wt;
      if (wr && !er) mmem[a] = d;
    end
    exp_q.push_back(e);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid === 1'b1) && n < 1000) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge PCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, n, wt;
    logic wr, er;
    logic [AW-1:0] a;
    bit seen;

    for (int i = 0; i < 256; i++) begin
      mmem[i] = '0;
      smem[i] = '0;
    end

    // Reset held with a pending command.
    PRESET = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 8'hAA; cmd_wdata = 32'h1234_5678;
    repeat (3) begin
      @(negedge PCLK);
      chk("reset_ctrl", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 0);
      chk("reset_paddr", PADDR, 0);
      chk("reset_pwdata", PWDATA, 0);
      chk("reset_rdata", rsp_rdata, 0);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("release_cmd_ready", cmd_ready, 1);
    chk("release_psel", PSEL, 0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("release_no_accept", PSEL, 0);

    // Zero-wait write then read, back to back.
    issue(1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, h1);
    issue(1'b0, 8'h10, 32'h0, 0, 1'b0, h2);
    chk("b2b_spacing", h2 - h1, 4);
    drain();

    // Wait states, slave error.
    issue(1'b0, 8'h04, 32'h0, 3, 1'b0, h1);
    issue(1'b1, 8'hFF, 32'hCAFE_F00D, 0, 1'b1, h1);
    drain();

    // Timeout and its boundaries, then a normal transfer.
    issue(1'b0, 8'h20, 32'h0, 1000, 1'b0, h1);
    issue(1'b0, 8'h10, 32'h0, 0, 1'b0, h1);
    issue(1'b0, 8'h10, 32'h0, TO - 1, 1'b0, h1);
    issue(1'b1, 8'h30, 32'h5555_AAAA, TO, 1'b0, h1);
    issue(1'b0, 8'h30, 32'h0, 0, 1'b0, h1);
    drain();

    // Response backpressure.
    rdy_mode = 2;
    issue(1'b1, 8'h40, 32'h0BAD_CAFE, 1, 1'b0, h1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      @(negedge PCLK);
      n++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      @(negedge PCLK);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", PSEL, 0);
    end
    rdy_mode = 0;
    drain();

    // Reset during ACCESS aborts with no response.
    issue(1'b0, 8'h08, 32'h0, 8, 1'b0, h1);
    n = 0;
    while (PENABLE !== 1'b1 && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("mid_reset_access_seen", PENABLE, 1);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("mid_reset_psel", PSEL, 0);
    chk("mid_reset_penable", PENABLE, 0);
    chk("mid_reset_rsp_valid", rsp_valid, 0);
    PRESET = 1'b1;
    exp_q.delete();
    bus_q.delete();
    seen = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1 || PSEL === 1'b1) seen = 1;
    end
    chk("mid_reset_quiet", seen, 0);
    issue(1'b0, 8'h10, 32'h0, 0, 1'b0, h1);
    drain();

    // Randomized traffic with random response backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 80; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15) * 4);
      n  = $urandom_range(0, 9);
      if (n < 6)       wt = $urandom_range(0, 3);
      else if (n == 6) wt = TO - 2 + $urandom_range(0, 2);
      else if (n == 7) wt = 40;
      else             wt = 1;
      er = ($urandom_range(0, 4) == 0);
      issue(wr, a, $urandom, wt, er, h1);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge PCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
